// File: rtl/divn_counter_74161_pkg.sv
// Shared widths, legal divide range and the terminal-value helper for the divide-by-N counter.
package divn_counter_74161_pkg;

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned DIV_N_MIN = 2;
    localparam int unsigned DIV_N_MAX = 256;

    // Last count value before the synchronous reload to zero.
    function automatic logic [CNT_W-1:0] term_value(input int unsigned div_n);
        return CNT_W'(div_n - 1);
    endfunction

endpackage

// File: rtl/counter_74161.sv
// One 4-bit 74161-style stage: async clear, sync load over count, ENP/ENT enables.
module counter_74161
    import divn_counter_74161_pkg::*;
(
    input  logic             clk,
    input  logic             areset_n,
    input  logic             load,
    input  logic             enp,
    input  logic             ent,
    input  logic [NIB_W-1:0] d,
    output logic [NIB_W-1:0] q,
    output logic             rco
);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (enp && ent) begin
            q <= q + NIB_W'(1);
        end
    end

    always_comb begin
        rco = ent & (q == {NIB_W{1'b1}});
    end

endmodule

// File: rtl/divn_counter_74161.sv
// Divide-by-N counter: two cascaded 74161 stages with terminal-count reload to zero.
module divn_counter_74161
    import divn_counter_74161_pkg::*;
#(
    parameter int unsigned DIV_N = 10
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             ena,
    input  logic             sload,
    input  logic [CNT_W-1:0] sdata,
    output logic [CNT_W-1:0] q,
    output logic             rco_lo,
    output logic             tick
);

    if (DIV_N < DIV_N_MIN || DIV_N > DIV_N_MAX) begin : g_bad_div_n
        $error("divn_counter_74161: DIV_N must be within 2..256");
    end

    localparam logic [CNT_W-1:0] TERM = term_value(DIV_N);

    logic             at_term;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [NIB_W-1:0] q_lo;
    logic [NIB_W-1:0] q_hi;
    logic             rco_hi_unused;

    always_comb begin
        at_term  = (q == TERM);
        // Both stages share one load strobe; terminal reload presents zero unless sload wins.
        load     = sload | (ena & at_term);
        load_val = sload ? sdata : '0;
        tick     = ena & ~sload & at_term;
        q        = {q_hi, q_lo};
    end

    counter_74161 u_stage_lo (
        .clk      (clk),
        .areset_n (areset_n),
        .load     (load),
        .enp      (ena),
        .ent      (ena),
        .d        (load_val[NIB_W-1:0]),
        .q        (q_lo),
        .rco      (rco_lo)
    );

    counter_74161 u_stage_hi (
        .clk      (clk),
        .areset_n (areset_n),
        .load     (load),
        .enp      (ena),
        .ent      (rco_lo),
        .d        (load_val[CNT_W-1:NIB_W]),
        .q        (q_hi),
        .rco      (rco_hi_unused)
    );

endmodule
